// File: rtl/fpu_addsub_pkg.sv
// rtl/fpu_addsub_pkg.sv - fp16 add/sub shared widths, FSM state type and field helpers
package fpu_addsub_pkg;

  localparam int FP_W      = 16;
  localparam int EXP_W     = 5;
  localparam int MANT_W    = 11;
  localparam int FRAC_W    = MANT_W - 1;
  localparam int BIAS      = 15;
  localparam int GRS_W     = 3;
  localparam int SHIFT_CAP = 13;
  localparam int SH_W      = MANT_W + 2;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic logic fp16_sign(input logic [FP_W-1:0] x);
    return x[FP_W-1];
  endfunction

  function automatic logic [EXP_W-1:0] fp16_exp(input logic [FP_W-1:0] x);
    return x[FP_W-2:FRAC_W];
  endfunction

  function automatic logic [FRAC_W-1:0] fp16_frac(input logic [FP_W-1:0] x);
    return x[FRAC_W-1:0];
  endfunction

endpackage

// File: rtl/fp16_unpack.sv
// rtl/fp16_unpack.sv - combinational fp16 field decode and classification
module fp16_unpack
  import fpu_addsub_pkg::*;
(
  input  logic [FP_W-1:0]   op,
  output logic              sign,
  output logic [EXP_W-1:0]  eff_exp,
  output logic [MANT_W-1:0] sig,
  output logic              is_nan,
  output logic              is_inf,
  output logic              is_zero
);

  logic [EXP_W-1:0]  e;
  logic [FRAC_W-1:0] f;

  // subnormals share exponent 1 with the smallest normals but have no hidden bit
  always_comb begin
    e       = fp16_exp(op);
    f       = fp16_frac(op);
    sign    = fp16_sign(op);
    eff_exp = (e == '0) ? EXP_W'(1) : e;
    sig     = {(e != '0), f};
    is_nan  = (e == '1) && (f != '0);
    is_inf  = (e == '1) && (f == '0);
    is_zero = (e == '0) && (f == '0);
  end

endmodule

// File: rtl/fpu_addsub_align.sv
// rtl/fpu_addsub_align.sv - fp16 add/sub operand ordering and iterative alignment stage
module fpu_addsub_align
  import fpu_addsub_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP_W-1:0]   op_a,
  input  logic [FP_W-1:0]   op_b,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] mant_l,
  output logic [MANT_W-1:0] mant_s,
  output logic              cin,
  output logic [EXP_W-1:0]  exp_l,
  output logic              sign_r,
  output logic [GRS_W-1:0]  grs,
  output logic              eff_sub,
  output logic              is_nan,
  output logic              is_inf
);

  logic              sa, sb_raw, sb;
  logic [EXP_W-1:0]  ea, eb;
  logic [MANT_W-1:0] siga, sigb;
  logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

  fp16_unpack u_unpack_a (
    .op(op_a), .sign(sa), .eff_exp(ea), .sig(siga),
    .is_nan(nan_a), .is_inf(inf_a), .is_zero(zero_a)
  );

  fp16_unpack u_unpack_b (
    .op(op_b), .sign(sb_raw), .eff_exp(eb), .sig(sigb),
    .is_nan(nan_b), .is_inf(inf_b), .is_zero(zero_b)
  );

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [SH_W-1:0]   sh_q;
  logic              sticky_q;
  logic              in_ready_q, out_valid_q;
  logic [MANT_W-1:0] mant_l_q, mant_s_q;
  logic [EXP_W-1:0]  exp_l_q;
  logic [GRS_W-1:0]  grs_q;
  logic              cin_q, sign_r_q, eff_sub_q, is_nan_q, is_inf_q;

  logic              esub, a_ge, tie, sgn_l;
  logic [MANT_W-1:0] sig_l, sig_sm;
  logic [EXP_W-1:0]  exp_lg, exp_sm, diff;
  logic [CNT_W-1:0]  d_cap;
  logic              spec_nan, spec_inf, special, accept;

  // order operands by magnitude and classify the operation
  always_comb begin
    sb     = sb_raw ^ sub;
    esub   = sa ^ sb;
    a_ge   = {ea, siga} >= {eb, sigb};
    tie    = ({ea, siga} == {eb, sigb}) || (zero_a && zero_b);
    sig_l  = a_ge ? siga : sigb;
    sig_sm = a_ge ? sigb : siga;
    exp_lg = a_ge ? ea : eb;
    exp_sm = a_ge ? eb : ea;
    // x - x is +0 in round-to-nearest
    sgn_l  = (tie && esub) ? 1'b0 : (a_ge ? sa : sb);
    diff   = exp_lg - exp_sm;
    d_cap  = (diff > EXP_W'(SHIFT_CAP)) ? CNT_W'(SHIFT_CAP) : diff[CNT_W-1:0];
    spec_nan = nan_a || nan_b || (inf_a && inf_b && esub);
    spec_inf = !spec_nan && (inf_a || inf_b);
    special  = spec_nan || spec_inf;
    accept   = in_valid && in_ready_q;
  end

  logic [SH_W-1:0]   sh_next;
  logic              sticky_next;
  logic [MANT_W-1:0] fin_sig, mant_s_fin;
  logic [GRS_W-1:0]  grs_raw, grs_fin;
  logic              fin_sub, cin_fin;

  // one-bit alignment step and the adder-ready form of the final shifter contents;
  // subtraction negates {sig_S, grs} so the adder sees L<<3 - S_ext exactly
  always_comb begin
    sh_next     = {1'b0, sh_q[SH_W-1:1]};
    sticky_next = sticky_q | sh_q[0];
    if (state_q == IDLE) begin
      fin_sig = sig_sm;
      grs_raw = '0;
      fin_sub = esub;
    end else begin
      fin_sig = sh_next[SH_W-1:2];
      grs_raw = {sh_next[1:0], sticky_next};
      fin_sub = eff_sub_q;
    end
    mant_s_fin = fin_sub ? ~fin_sig : fin_sig;
    grs_fin    = fin_sub ? (GRS_W'(0) - grs_raw) : grs_raw;
    cin_fin    = fin_sub && (grs_raw == '0);
  end

  // next-state logic: zero-distance and special operations bypass ALIGN
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (special || d_cap == '0) ? HOLD : ALIGN;
      ALIGN:   if (cnt_q == CNT_W'(1)) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state, handshake flags, shifter, counter and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      sticky_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      mant_l_q    <= '0;
      mant_s_q    <= '0;
      exp_l_q     <= '0;
      grs_q       <= '0;
      cin_q       <= 1'b0;
      sign_r_q    <= 1'b0;
      eff_sub_q   <= 1'b0;
      is_nan_q    <= 1'b0;
      is_inf_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == HOLD);
      case (state_q)
        IDLE: begin
          if (accept) begin
            sh_q     <= {sig_sm, 2'b00};
            sticky_q <= 1'b0;
            cnt_q    <= d_cap;
            is_nan_q <= spec_nan;
            is_inf_q <= spec_inf;
            if (special) begin
              mant_l_q  <= '0;
              mant_s_q  <= '0;
              exp_l_q   <= '0;
              grs_q     <= '0;
              cin_q     <= 1'b0;
              eff_sub_q <= 1'b0;
              sign_r_q  <= spec_inf && (inf_a ? sa : sb);
            end else begin
              mant_l_q  <= sig_l;
              exp_l_q   <= exp_lg;
              sign_r_q  <= sgn_l;
              eff_sub_q <= esub;
              if (d_cap == '0) begin
                mant_s_q <= mant_s_fin;
                grs_q    <= grs_fin;
                cin_q    <= cin_fin;
              end else begin
                mant_s_q <= '0;
                grs_q    <= '0;
                cin_q    <= 1'b0;
              end
            end
          end
        end
        ALIGN: begin
          sh_q     <= sh_next;
          sticky_q <= sticky_next;
          cnt_q    <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            mant_s_q <= mant_s_fin;
            grs_q    <= grs_fin;
            cin_q    <= cin_fin;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign mant_l    = mant_l_q;
  assign mant_s    = mant_s_q;
  assign cin       = cin_q;
  assign exp_l     = exp_l_q;
  assign sign_r    = sign_r_q;
  assign grs       = grs_q;
  assign eff_sub   = eff_sub_q;
  assign is_nan    = is_nan_q;
  assign is_inf    = is_inf_q;

endmodule

// File: tb/tb_fpu_addsub_align.sv
// tb/tb_fpu_addsub_align.sv - directed self-checking bench for fpu_addsub_align
module tb_fpu_addsub_align;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a, op_b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] mant_l, mant_s;
  logic        cin;
  logic [4:0]  exp_l;
  logic        sign_r;
  logic [2:0]  grs;
  logic        eff_sub, is_nan, is_inf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fpu_addsub_align dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .mant_l(mant_l), .mant_s(mant_s), .cin(cin), .exp_l(exp_l), .sign_r(sign_r),
    .grs(grs), .eff_sub(eff_sub), .is_nan(is_nan), .is_inf(is_inf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] snap();
    return {3'b0, mant_l, mant_s, cin, exp_l, sign_r, grs, eff_sub, is_nan, is_inf};
  endfunction

  // issue one operation, check latency and all result fields, optionally hold off out_ready
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input int lat, input logic [10:0] e_ml,
                        input logic [10:0] e_ms, input logic e_cin, input logic [4:0] e_exp,
                        input logic e_sign, input logic [2:0] e_grs, input logic e_esub,
                        input logic e_nan, input logic e_inf, input bit bp);
    int k;
    logic [31:0] held;
    k = 0;
    while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
    chk({name, ".in_ready"}, in_ready, 1);
    out_ready = !bp;
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = ~a; op_b = ~b; sub = ~s;
    chk({name, ".busy"}, in_ready, 0);
    k = 1;
    while (!out_valid && k < 40) begin @(posedge clk); #1; k++; end
    chk({name, ".latency"}, k, lat);
    chk({name, ".mant_l"}, mant_l, e_ml);
    chk({name, ".mant_s"}, mant_s, e_ms);
    chk({name, ".cin"}, cin, e_cin);
    chk({name, ".exp_l"}, exp_l, e_exp);
    chk({name, ".sign_r"}, sign_r, e_sign);
    chk({name, ".grs"}, grs, e_grs);
    chk({name, ".eff_sub"}, eff_sub, e_esub);
    chk({name, ".is_nan"}, is_nan, e_nan);
    chk({name, ".is_inf"}, is_inf, e_inf);
    if (bp) begin
      held = snap();
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        chk({name, ".bp_valid"}, out_valid, 1);
        chk({name, ".bp_stable"}, snap(), held);
        chk({name, ".bp_in_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({name, ".done_valid"}, out_valid, 0);
    chk({name, ".done_in_ready"}, in_ready, 1);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.fields", snap(), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.in_ready_rise", in_ready, 1);

    //      name      a        b        s  lat ml      ms      cin exp sg grs     es nan inf bp
    run_op("eq_add",  16'h3C00, 16'h3C00, 0, 1, 11'h400, 11'h400, 0, 15, 0, 3'b000, 0, 0, 0, 0);
    run_op("swap_sub",16'h3C00, 16'h4000, 1, 2, 11'h400, 11'h5FF, 1, 16, 1, 3'b000, 1, 0, 0, 0);
    run_op("cap",     16'h7800, 16'h0001, 0, 14, 11'h400, 11'h000, 0, 30, 0, 3'b001, 0, 0, 0, 0);
    run_op("inf_inf", 16'h7C00, 16'h7C00, 1, 1, 11'h000, 11'h000, 0, 0, 0, 3'b000, 0, 1, 0, 0);
    run_op("bp",      16'h3C00, 16'h3C00, 0, 1, 11'h400, 11'h400, 0, 15, 0, 3'b000, 0, 0, 0, 1);
    run_op("tie_sub", 16'h3C00, 16'h3C00, 1, 1, 11'h400, 11'h3FF, 1, 15, 0, 3'b000, 1, 0, 0, 0);
    run_op("neg_sub", 16'hBC00, 16'h3C00, 1, 1, 11'h400, 11'h400, 0, 15, 1, 3'b000, 0, 0, 0, 0);
    run_op("sticky_s",16'h4800, 16'h3C01, 1, 4, 11'h400, 11'h77F, 0, 18, 0, 3'b111, 1, 0, 0, 0);
    run_op("guard_a", 16'h4800, 16'h3C04, 0, 4, 11'h400, 11'h080, 0, 18, 0, 3'b100, 0, 0, 0, 0);
    run_op("inf_add", 16'h7C00, 16'h3C00, 0, 1, 11'h000, 11'h000, 0, 0, 0, 3'b000, 0, 0, 1, 0);
    run_op("inf_neg", 16'h3C00, 16'h7C00, 1, 1, 11'h000, 11'h000, 0, 0, 1, 3'b000, 0, 0, 1, 0);
    run_op("nan_in",  16'h7E00, 16'h3C00, 0, 1, 11'h000, 11'h000, 0, 0, 0, 3'b000, 0, 1, 0, 0);

    // reset in the middle of a long alignment
    op_a = 16'h7800; op_b = 16'h0001; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.in_ready", in_ready, 0);
    chk("midrst.fields", snap(), 0);
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) k++;
    end
    chk("midrst.no_output", k, 0);
    chk("midrst.idle", in_ready, 1);
    run_op("post_rst",16'h3C00, 16'h3C00, 0, 1, 11'h400, 11'h400, 0, 15, 0, 3'b000, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
